px_stream_router: RTL and testbench

// - N-source pixel router between SPI/LFSR-style pixel sources and the gray/sobel processing pipe.
// - Replaces fixed 2-way ternary muxing with a selectable, frame-counted, FIFO-buffered path with backpressure.
// - Sits between the source blocks and top_gray_sobel. Gives frame-done and overflow status to the top level.

---
 rtl/px_stream_router_if.sv | 32 +++
 rtl/px_stream_router.sv | 108 ++++++++++
 tb/tb_px_stream_router.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/px_stream_router_if.sv
// px_stream_router_if: pixel-router control, source and processing-pipe signals.
// The router connects on the slave modport; the sources/control side connects on the master modport.
interface px_stream_router_if #(
    parameter int PX_W     = 8,
    parameter int N_SRC    = 2,
    parameter int FRAME_PX = 1024
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(FRAME_PX + 1);
    logic [SEL_W-1:0]      sel;
    logic                  start;
    logic                  abort;
    logic [N_SRC*PX_W-1:0] src_px;
    logic [N_SRC-1:0]      src_rdy;
    logic [N_SRC-1:0]      src_ack;
    logic [PX_W-1:0]       proc_px;
    logic                  proc_rdy;
    logic                  proc_stall;
    logic                  busy;
    logic                  frame_done;
    logic                  overflow;
    logic [CNT_W-1:0]      px_count;
    logic [PX_W-1:0]       checksum;
    modport master (
        output sel, start, abort, src_px, src_rdy, proc_stall,
        input  src_ack, proc_px, proc_rdy, busy, frame_done, overflow, px_count, checksum
    );
    modport slave (
        input  sel, start, abort, src_px, src_rdy, proc_stall,
        output src_ack, proc_px, proc_rdy, busy, frame_done, overflow, px_count, checksum
    );
endinterface

// File: rtl/px_stream_router.sv
// px_stream_router: frame-counted, FIFO-buffered N-source pixel router with backpressure.
// Optional frame checksum of popped pixels enabled by defining ROUTER_CHECKSUM_EN.
module px_stream_router #(
    parameter int PX_W       = 8,
    parameter int N_SRC      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_PX   = 1024
) (
    input logic clk,
    input logic nreset,
    px_stream_router_if.slave bus
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(FRAME_PX + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t            state, state_nx;
    logic [SEL_W-1:0]  sel_q;
    logic [PX_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    logic [CNT_W-1:0]  px_count;
    logic              overflow, proc_rdy;
    logic [PX_W-1:0]   proc_px;
    logic [N_SRC-1:0]  src_ack;
    logic              active, flush, begin_frame, pop, strobe, push_ok, push, drop, last_px;
    logic [PX_W-1:0]   px_in;
    assign active      = (state == RUN) || (state == DRAIN);
    assign flush       = active && bus.abort;
    assign begin_frame = (state == IDLE) && bus.start;
    assign pop         = active && !bus.abort && (occ != '0) && !bus.proc_stall;
    assign strobe      = (state == RUN) && !bus.abort && bus.src_rdy[sel_q];
    // A pop in the same cycle frees the slot, so a full FIFO can still take a pixel
    assign push_ok     = (occ != (AW+1)'(FIFO_DEPTH)) || pop;
    assign push        = strobe && push_ok;
    assign drop        = strobe && !push_ok;
    assign last_px     = push && (px_count == CNT_W'(FRAME_PX - 1));
    assign px_in       = bus.src_px[sel_q*PX_W +: PX_W];
    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = bus.abort ? IDLE : last_px ? DRAIN : RUN;
            DRAIN:   state_nx = bus.abort ? IDLE : (occ == '0) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= px_in;
    end
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            sel_q    <= '0;
            px_count <= '0;
            overflow <= 1'b0;
            src_ack  <= '0;
            proc_px  <= '0;
            proc_rdy <= 1'b0;
        end else begin
            src_ack  <= push ? (N_SRC'(1) << sel_q) : '0;
            proc_rdy <= pop;
            if (pop) begin
                proc_px <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                px_count <= px_count + 1'b1;
            end
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
            if (drop) overflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end
            if (begin_frame) begin
                sel_q    <= bus.sel;
                px_count <= '0;
                overflow <= 1'b0;
            end
        end
    end
`ifdef ROUTER_CHECKSUM_EN
    logic [PX_W-1:0] checksum;
    always_ff @(posedge clk) begin
        if (!nreset || begin_frame) checksum <= '0;
        else if (pop)               checksum <= checksum ^ mem[rd_ptr];
    end
    assign bus.checksum = checksum;
`else
    assign bus.checksum = '0;
`endif
    assign bus.src_ack    = src_ack;
    assign bus.proc_px    = proc_px;
    assign bus.proc_rdy   = proc_rdy;
    assign bus.busy       = active;
    assign bus.frame_done = (state == DONE);
    assign bus.overflow   = overflow;
    assign bus.px_count   = px_count;
endmodule

// File: tb/tb_px_stream_router.sv
// tb_px_stream_router: random and directed stimulus for px_stream_router, checked every cycle
// against a queue-based frame model; checksum expectation follows ROUTER_CHECKSUM_EN.
module tb_px_stream_router;
    localparam int PX_W = 8, N_SRC = 2, DEPTH = 4, FRAME_PX = 6;
`ifdef ROUTER_CHECKSUM_EN
    localparam logic [7:0] CKS_A = 8'h77;
`else
    localparam logic [7:0] CKS_A = 8'h00;
`endif
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;
    px_stream_router_if #(.PX_W(PX_W), .N_SRC(N_SRC), .FRAME_PX(FRAME_PX)) bus ();
    px_stream_router #(.PX_W(PX_W), .N_SRC(N_SRC), .FIFO_DEPTH(DEPTH), .FRAME_PX(FRAME_PX)) dut (
        .clk(clk), .nreset(nreset), .bus(bus)
    );
    int errors = 0, checks = 0, done_seen = 0, rdy_seen = 0;
    int m_st = 0, m_cnt = 0, m_sel = 0;
    logic [7:0] q[$];
    logic [7:0] m_px = 0, m_cks = 0;
    logic [1:0] m_ack = 0;
    bit m_ovf = 0, m_rdy = 0;
    logic [7:0] pat [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    // Frame model: 0 idle, 1 accepting, 2 draining, 3 done
    task automatic model_step();
        bit pop, strobe, ok;
        logic [7:0] pin;
        if (!nreset) begin
            m_st = 0; q.delete(); m_cnt = 0; m_ovf = 0; m_cks = 0; m_px = 0; m_rdy = 0; m_ack = 0;
        end else if (m_st == 0) begin
            m_rdy = 0; m_ack = 0;
            if (bus.start) begin
                m_sel = int'(bus.sel); m_cnt = 0; m_ovf = 0; m_cks = 0; m_st = 1;
            end
        end else if (m_st == 3) begin
            m_rdy = 0; m_ack = 0; m_st = 0;
        end else if (bus.abort) begin
            q.delete(); m_rdy = 0; m_ack = 0; m_st = 0;
        end else begin
            pop = q.size() > 0 && !bus.proc_stall;
            strobe = m_st == 1 && bus.src_rdy[m_sel];
            ok = q.size() < DEPTH || pop;
            pin = bus.src_px[m_sel*PX_W +: PX_W];
            if (m_st == 2 && q.size() == 0) m_st = 3;
            m_rdy = pop;
            if (pop) begin
                m_px = q.pop_front();
                m_cks ^= m_px;
            end
            m_ack = 0;
            if (strobe && ok) begin
                q.push_back(pin);
                m_cnt++;
                m_ack = 2'(1 << m_sel);
                if (m_cnt == FRAME_PX) m_st = 2;
            end else if (strobe) m_ovf = 1;
        end
    endtask
    task automatic compare();
        check("proc_rdy", bus.proc_rdy, m_rdy);
        check("proc_px", bus.proc_px, m_px);
        check("src_ack", bus.src_ack, m_ack);
        check("busy", bus.busy, m_st == 1 || m_st == 2);
        check("frame_done", bus.frame_done, m_st == 3);
        check("overflow", bus.overflow, m_ovf);
        check("px_count", bus.px_count, m_cnt);
`ifdef ROUTER_CHECKSUM_EN
        check("checksum", bus.checksum, m_cks);
`else
        check("checksum", bus.checksum, 0);
`endif
        done_seen += int'(bus.frame_done);
        rdy_seen += int'(bus.proc_rdy);
    endtask
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask
    task automatic strobe1(input logic [7:0] p, input bit also0);
        bus.src_px = {p, 8'($urandom)};
        bus.src_rdy = {1'b1, also0};
        step();
        bus.src_rdy = 2'b00;
    endtask
    task automatic start_frame(input logic s);
        bus.sel = s; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.sel = ~s;
    endtask
    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && done_seen == 0; i++) step();
        check(tag, done_seen, 1);
    endtask
    initial begin
        bus.sel = 0; bus.start = 0; bus.abort = 0; bus.src_px = 0; bus.src_rdy = 0; bus.proc_stall = 0;
        step();
        step();
        nreset = 1'b1;
        // 6-pixel frame on src1 with src0 strobing alongside
        start_frame(1'b1);
        done_seen = 0;
        for (int i = 0; i < 6; i++) strobe1(pat[i], 1'b1);
        wait_done("frameA_done");
        check("frameA_count", bus.px_count, 6);
        check("frameA_cks", bus.checksum, CKS_A);
        step();
        // overflow under stall, then drain in order
        start_frame(1'b1);
        bus.proc_stall = 1'b1;
        for (int i = 0; i < 5; i++) strobe1(pat[i], 1'b0);
        check("ovf_count", bus.px_count, 4);
        check("ovf_flag", bus.overflow, 1);
        bus.proc_stall = 1'b0;
        repeat (6) step();
        done_seen = 0;
        strobe1(8'hA5, 1'b0);
        strobe1(8'h5A, 1'b0);
        wait_done("frameB_done");
        step();
        // full FIFO with stall released on the same edge as a strobe
        start_frame(1'b1);
        bus.proc_stall = 1'b1;
        for (int i = 0; i < 4; i++) strobe1(pat[i], 1'b0);
        bus.proc_stall = 1'b0;
        strobe1(8'hC3, 1'b0);
        check("release_ovf", bus.overflow, 0);
        check("release_count", bus.px_count, 5);
        done_seen = 0;
        strobe1(8'h3C, 1'b0);
        wait_done("frameC_done");
        step();
        // abort in DRAIN with 2 pixels queued
        start_frame(1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.src_px = {8'($urandom), pat[i]};
            bus.src_rdy = 2'b01;
            step();
        end
        bus.src_rdy = 2'b00;
        step();
        bus.proc_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.src_px = {8'($urandom), pat[i+4]};
            bus.src_rdy = 2'b01;
            step();
        end
        bus.src_rdy = 2'b00;
        check("drain_busy", bus.busy, 1);
        bus.abort = 1'b1;
        bus.proc_stall = 1'b0;
        done_seen = 0; rdy_seen = 0;
        step();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        repeat (5) step();
        check("abort_no_rdy", rdy_seen, 0);
        check("abort_no_done", done_seen, 0);
        // synchronous reset with 3 pixels held in the FIFO
        start_frame(1'b1);
        bus.proc_stall = 1'b1;
        for (int i = 0; i < 3; i++) strobe1(pat[i], 1'b0);
        nreset = 1'b0;
        step();
        check("rst_rdy", bus.proc_rdy, 0);
        check("rst_count", bus.px_count, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        nreset = 1'b1;
        bus.proc_stall = 1'b0;
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(3) == 0);
            bus.sel = 1'($urandom);
            bus.src_px = 16'($urandom);
            bus.src_rdy = {($urandom_range(9) < 6), ($urandom_range(9) < 6)};
            bus.proc_stall = ($urandom_range(9) < 3);
            bus.abort = ($urandom_range(63) == 0);
            nreset = ($urandom_range(399) != 0);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
